// File: rtl/weight_bram_loader.sv
// weight_bram_loader
// Write-side feeder for the multi-lane weight BRAM bank. A valid/ready stream
// of weight words is spread round-robin across the lanes: word k goes to lane
// k mod NUM_BRAMS at row cfg_base_addr + k/NUM_BRAMS (modulo 2**ADDR_WIDTH).
// Completion is reported with a single-cycle done pulse aligned with the last
// write, so the layer controller can start compute once weights are resident.
//
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   start            one-cycle pulse, sampled only in IDLE; latches cfg_*
//   cfg_base_addr    first row written in every lane
//   cfg_rows         rows per lane (0..DEPTH); 0 completes immediately
//   s_valid/s_ready  stream handshake; s_data word, s_last end marker
//   w_we             one-hot lane write enable (registered)
//   w_addr_wr_flat   write address, replicated on every lane (registered)
//   w_din_flat       write data on the selected lane, zero elsewhere
//   busy             load in progress (LOAD or FLUSH)
//   done             one-cycle completion pulse
//   err_last         sticky: s_last disagreed with the configured length
module weight_bram_loader #(
   parameter int DW         = 16,
   parameter int NUM_BRAMS  = 16,
   parameter int ADDR_WIDTH = 11,
   parameter int DEPTH      = 2048
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic                             start,
   input  logic [ADDR_WIDTH-1:0]            cfg_base_addr,
   input  logic [ADDR_WIDTH:0]              cfg_rows,
   input  logic                             s_valid,
   output logic                             s_ready,
   input  logic [DW-1:0]                    s_data,
   input  logic                             s_last,
   output logic [NUM_BRAMS-1:0]             w_we,
   output logic [NUM_BRAMS*ADDR_WIDTH-1:0]  w_addr_wr_flat,
   output logic [NUM_BRAMS*DW-1:0]          w_din_flat,
   output logic                             busy,
   output logic                             done,
   output logic                             err_last
);

   localparam int LANE_W = $clog2(NUM_BRAMS);
   // Row counter must reach DEPTH, so it is one bit wider than an address.
   localparam int ROW_W  = $clog2(DEPTH) + 1;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_FLUSH = 2'd2
   } state_t;

   state_t                          state_r, state_s;
   logic [LANE_W-1:0]               lane_r, lane_s;
   logic [ROW_W-1:0]                row_r, row_s;
   logic [ROW_W-1:0]                rows_r, rows_s;
   logic [ADDR_WIDTH-1:0]           base_r, base_s;
   logic                            err_r, err_s;
   logic                            done_r, done_s;
   logic                            ready_r, busy_r;
   logic [NUM_BRAMS-1:0]            we_r, we_s;
   logic [NUM_BRAMS*ADDR_WIDTH-1:0] addr_r, addr_s;
   logic [NUM_BRAMS*DW-1:0]         din_r, din_s;
   logic                            hs_s;
   logic                            final_s;
   logic [ADDR_WIDTH-1:0]           wr_addr_s;

   // ready_r is high exactly while in LOAD, so it alone qualifies a handshake.
   assign hs_s      = s_valid & ready_r;
   assign final_s   = (lane_r == LANE_W'(NUM_BRAMS - 1)) &&
                      (row_r == (rows_r - {{(ROW_W-1){1'b0}}, 1'b1}));
   assign wr_addr_s = base_r + row_r[ADDR_WIDTH-1:0];

   // State, configuration, counters and all registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= ST_IDLE;
         lane_r  <= {LANE_W{1'b0}};
         row_r   <= {ROW_W{1'b0}};
         rows_r  <= {ROW_W{1'b0}};
         base_r  <= {ADDR_WIDTH{1'b0}};
         err_r   <= 1'b0;
         done_r  <= 1'b0;
         ready_r <= 1'b0;
         busy_r  <= 1'b0;
         we_r    <= {NUM_BRAMS{1'b0}};
         addr_r  <= {(NUM_BRAMS*ADDR_WIDTH){1'b0}};
         din_r   <= {(NUM_BRAMS*DW){1'b0}};
      end else begin
         state_r <= state_s;
         lane_r  <= lane_s;
         row_r   <= row_s;
         rows_r  <= rows_s;
         base_r  <= base_s;
         err_r   <= err_s;
         done_r  <= done_s;
         ready_r <= (state_s == ST_LOAD);
         busy_r  <= (state_s != ST_IDLE);
         we_r    <= we_s;
         addr_r  <= addr_s;
         din_r   <= din_s;
      end
   end

   // Next-state, counter advance and next write-port values.
   always_comb begin
      state_s = state_r;
      lane_s  = lane_r;
      row_s   = row_r;
      rows_s  = rows_r;
      base_s  = base_r;
      err_s   = err_r;
      done_s  = 1'b0;
      we_s    = {NUM_BRAMS{1'b0}};
      addr_s  = addr_r;
      din_s   = {(NUM_BRAMS*DW){1'b0}};
      case (state_r)
         ST_IDLE: begin
            if (start) begin
               if (cfg_rows != {(ADDR_WIDTH+1){1'b0}}) begin
                  rows_s  = ROW_W'(cfg_rows);
                  base_s  = cfg_base_addr;
                  err_s   = 1'b0;
                  lane_s  = {LANE_W{1'b0}};
                  row_s   = {ROW_W{1'b0}};
                  state_s = ST_LOAD;
               end else begin
                  // Empty load: nothing to write, report completion at once.
                  done_s = 1'b1;
               end
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_LOAD: begin
            if (hs_s) begin
               for (int i = 0; i < NUM_BRAMS; i++) begin
                  addr_s[i*ADDR_WIDTH +: ADDR_WIDTH] = wr_addr_s;
                  if (lane_r == LANE_W'(i)) begin
                     we_s[i]          = 1'b1;
                     din_s[i*DW +: DW] = s_data;
                  end else begin
                     we_s[i]          = 1'b0;
                     din_s[i*DW +: DW] = {DW{1'b0}};
                  end
               end
               if (lane_r == LANE_W'(NUM_BRAMS - 1)) begin
                  lane_s = {LANE_W{1'b0}};
                  row_s  = row_r + {{(ROW_W-1){1'b0}}, 1'b1};
               end else begin
                  lane_s = lane_r + {{(LANE_W-1){1'b0}}, 1'b1};
               end
               // An early s_last or a missing s_last on the last word both end
               // the load; either disagreement is flagged.
               if (final_s || s_last) begin
                  state_s = ST_FLUSH;
                  done_s  = 1'b1;
                  if (final_s != s_last) begin
                     err_s = 1'b1;
                  end else begin
                     err_s = err_r;
                  end
               end else begin
                  state_s = ST_LOAD;
               end
            end else begin
               state_s = ST_LOAD;
            end
         end
         ST_FLUSH: begin
            state_s = ST_IDLE;
         end
         default: begin
            state_s = ST_IDLE;
         end
      endcase
   end

   assign s_ready        = ready_r;
   assign busy           = busy_r;
   assign done           = done_r;
   assign err_last       = err_r;
   assign w_we           = we_r;
   assign w_addr_wr_flat = addr_r;
   assign w_din_flat     = din_r;

endmodule

// File: tb/tb_weight_bram_loader.sv
// Directed testbench for weight_bram_loader: table of load scenarios run by a
// cycle-accurate expectation loop, plus hand sequences for empty load, start
// while busy and asynchronous reset in the middle of a load.
module tb_weight_bram_loader;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         start;
   logic [10:0]  cfg_base_addr;
   logic [11:0]  cfg_rows;
   logic         s_valid;
   logic         s_ready;
   logic [15:0]  s_data;
   logic         s_last;
   logic [15:0]  w_we;
   logic [175:0] w_addr_wr_flat;
   logic [255:0] w_din_flat;
   logic         busy;
   logic         done;
   logic         err_last;

   int checks = 0;
   int errors = 0;
   logic [175:0] hold_addr;

   weight_bram_loader dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .start          (start),
      .cfg_base_addr  (cfg_base_addr),
      .cfg_rows       (cfg_rows),
      .s_valid        (s_valid),
      .s_ready        (s_ready),
      .s_data         (s_data),
      .s_last         (s_last),
      .w_we           (w_we),
      .w_addr_wr_flat (w_addr_wr_flat),
      .w_din_flat     (w_din_flat),
      .busy           (busy),
      .done           (done),
      .err_last       (err_last)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [10:0] base;
      logic [11:0] rows;
      bit          gap;        // s_valid only on every other cycle
      int          last_idx;   // word carrying s_last, -1 for none
      bit          mid_start;  // pulse start again during the load
      int          exp_writes;
      bit          exp_err;
   } vec_t;

   vec_t vecs[6];

   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   function automatic logic [15:0] word_of(input int k);
      return 16'(k * 37 + 16'h8001);
   endfunction

   function automatic logic [175:0] rep_addr(input int a);
      logic [175:0] r;
      r = '0;
      for (int i = 0; i < 16; i++) r[i*11 +: 11] = 11'(a);
      return r;
   endfunction

   task automatic run_case(input vec_t v, input int id);
      int  total;
      int  k;
      int  pk;
      int  cyc;
      int  writes;
      bit  pend;
      bit  pfinal;
      bit  finished;
      logic [15:0]  exp_we;
      logic [255:0] exp_din;
      total = int'(v.rows) * 16;
      k = 0; pk = 0; cyc = 0; writes = 0;
      pend = 1'b0; pfinal = 1'b0; finished = 1'b0;
      cfg_base_addr = v.base;
      cfg_rows      = v.rows;
      start         = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk($sformatf("v%0d_err_clear", id), 256'(err_last), 256'(1'b0));
      while (!finished && cyc < 400) begin
         exp_we  = '0;
         exp_din = '0;
         if (pend) begin
            exp_we[pk % 16] = 1'b1;
            exp_din[(pk % 16)*16 +: 16] = word_of(pk);
            hold_addr = rep_addr((int'(v.base) + pk / 16) % 2048);
            writes++;
         end
         chk($sformatf("v%0d_c%0d_we", id, cyc), 256'(w_we), 256'(exp_we));
         chk($sformatf("v%0d_c%0d_din", id, cyc), w_din_flat, exp_din);
         chk($sformatf("v%0d_c%0d_addr", id, cyc), 256'(w_addr_wr_flat), 256'(hold_addr));
         chk($sformatf("v%0d_c%0d_done", id, cyc), 256'(done), 256'(pfinal));
         chk($sformatf("v%0d_c%0d_busy", id, cyc), 256'(busy), 256'(1'b1));
         chk($sformatf("v%0d_c%0d_ready", id, cyc), 256'(s_ready), 256'(!pfinal));
         if (pfinal) begin
            finished = 1'b1;
         end else begin
            if (v.mid_start && cyc == 4) begin
               start = 1'b1; cfg_rows = 12'd5; cfg_base_addr = 11'd100;
            end else begin
               start = 1'b0;
            end
            if (!v.gap || (cyc % 2 == 0)) begin
               s_valid = 1'b1;
               s_data  = word_of(k);
               s_last  = (k == v.last_idx);
            end else begin
               s_valid = 1'b0;
               s_data  = 16'h0000;
               s_last  = 1'b0;
            end
            pend   = s_valid && s_ready;
            pk     = k;
            pfinal = pend && (k == total - 1 || k == v.last_idx);
            if (pend) k++;
            cyc++;
            @(negedge clk);
         end
      end
      if (!finished) begin
         errors++;
         $display("FAIL v%0d_timeout actual=no_done required=done", id);
      end
      s_valid = 1'b0; s_last = 1'b0; start = 1'b0;
      @(negedge clk);
      chk($sformatf("v%0d_end_busy", id), 256'(busy), 256'(1'b0));
      chk($sformatf("v%0d_end_we", id), 256'(w_we), 256'(16'h0000));
      chk($sformatf("v%0d_end_done", id), 256'(done), 256'(1'b0));
      chk($sformatf("v%0d_end_ready", id), 256'(s_ready), 256'(1'b0));
      chk($sformatf("v%0d_end_addr_hold", id), 256'(w_addr_wr_flat), 256'(hold_addr));
      chk($sformatf("v%0d_err_last", id), 256'(err_last), 256'(v.exp_err));
      chk($sformatf("v%0d_writes", id), 256'(writes), 256'(v.exp_writes));
   endtask

   initial begin
      vecs[0] = '{base: 11'd0,    rows: 12'd2, gap: 1'b0, last_idx: 31, mid_start: 1'b0, exp_writes: 32, exp_err: 1'b0};
      vecs[1] = '{base: 11'd0,    rows: 12'd2, gap: 1'b1, last_idx: 31, mid_start: 1'b0, exp_writes: 32, exp_err: 1'b0};
      vecs[2] = '{base: 11'd2046, rows: 12'd3, gap: 1'b0, last_idx: 47, mid_start: 1'b0, exp_writes: 48, exp_err: 1'b0};
      vecs[3] = '{base: 11'd0,    rows: 12'd2, gap: 1'b0, last_idx: 20, mid_start: 1'b0, exp_writes: 21, exp_err: 1'b1};
      vecs[4] = '{base: 11'd5,    rows: 12'd1, gap: 1'b0, last_idx: -1, mid_start: 1'b0, exp_writes: 16, exp_err: 1'b1};
      vecs[5] = '{base: 11'd7,    rows: 12'd2, gap: 1'b0, last_idx: 31, mid_start: 1'b1, exp_writes: 32, exp_err: 1'b0};

      rst_n = 1'b0; start = 1'b0; cfg_base_addr = '0; cfg_rows = '0;
      s_valid = 1'b0; s_data = '0; s_last = 1'b0;
      hold_addr = '0;
      @(negedge clk);
      @(negedge clk);
      chk("rst_ready", 256'(s_ready), 256'(1'b0));
      chk("rst_we", 256'(w_we), 256'(16'h0000));
      chk("rst_addr", 256'(w_addr_wr_flat), 256'(176'h0));
      chk("rst_din", w_din_flat, 256'h0);
      chk("rst_busy", 256'(busy), 256'(1'b0));
      chk("rst_done", 256'(done), 256'(1'b0));
      chk("rst_err", 256'(err_last), 256'(1'b0));
      rst_n = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 6; i++) run_case(vecs[i], i);

      // Empty load: done next cycle, no writes, never ready.
      cfg_rows = 12'd0; cfg_base_addr = 11'd9; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("zero_done", 256'(done), 256'(1'b1));
      chk("zero_busy", 256'(busy), 256'(1'b0));
      chk("zero_ready", 256'(s_ready), 256'(1'b0));
      chk("zero_we", 256'(w_we), 256'(16'h0000));
      @(negedge clk);
      chk("zero_done_pulse", 256'(done), 256'(1'b0));
      chk("zero_ready2", 256'(s_ready), 256'(1'b0));
      chk("zero_we2", 256'(w_we), 256'(16'h0000));

      // Asynchronous reset after ten handshakes.
      cfg_rows = 12'd2; cfg_base_addr = 11'd0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 10; i++) begin
         s_valid = 1'b1; s_data = word_of(i); s_last = 1'b0;
         @(negedge clk);
      end
      s_valid = 1'b0;
      chk("mid_we_pending", 256'(w_we), 256'(16'h0200));
      rst_n = 1'b0;
      #1;
      chk("arst_we", 256'(w_we), 256'(16'h0000));
      chk("arst_busy", 256'(busy), 256'(1'b0));
      chk("arst_ready", 256'(s_ready), 256'(1'b0));
      chk("arst_din", w_din_flat, 256'h0);
      chk("arst_addr", 256'(w_addr_wr_flat), 256'(176'h0));
      hold_addr = '0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk("post_rst_idle_busy", 256'(busy), 256'(1'b0));
      chk("post_rst_idle_ready", 256'(s_ready), 256'(1'b0));
      run_case(vecs[0], 6);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
